ram_row_loader: RTL and testbench

RAM_ROW_LOADER -- requirements
Module: ram_row_loader

---
 rtl/ram_row_loader.sv | 137 +++++++++++++
 tb/tb_ram_row_loader.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_row_loader.sv
// ram_row_loader: packs a byte stream into DESIGN_SIZE-lane rows and writes
// each completed row to consecutive RAM addresses through a single write port.
module ram_row_loader #(
  parameter int AWIDTH      = 10,
  parameter int DESIGN_SIZE = 16,
  parameter int DWIDTH      = 8
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          start,
  input  logic                          abort,
  input  logic [AWIDTH-1:0]             base_addr,
  input  logic [AWIDTH-1:0]             num_rows,
  input  logic                          in_valid,
  input  logic [DWIDTH-1:0]             in_data,
  output logic                          in_ready,
  output logic [AWIDTH-1:0]             addr1,
  output logic [DESIGN_SIZE*DWIDTH-1:0] d1,
  output logic [DESIGN_SIZE-1:0]        we1,
  output logic                          busy,
  output logic                          done
);

  localparam int LW = (DESIGN_SIZE > 1) ? $clog2(DESIGN_SIZE) : 1;
  localparam int RW = DESIGN_SIZE * DWIDTH;
  localparam logic [LW-1:0] LAST_LANE = LW'(DESIGN_SIZE - 1);

  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

  state_t            state;
  state_t            state_next;
  logic [AWIDTH-1:0] base_reg;
  logic [AWIDTH-1:0] rows_reg;
  logic [AWIDTH-1:0] row_reg;
  logic [LW-1:0]     lane_reg;
  logic [RW-1:0]     row_buf_reg;
  logic [RW-1:0]     row_merged;
  logic [RW-1:0]     d1_reg;
  logic [AWIDTH-1:0] addr1_reg;
  logic              take;
  logic              last_lane;
  logic              last_row;

  // A byte is kept only when it transfers and the load is not being aborted;
  // a byte offered alongside abort belongs to the discarded partial row.
  assign take      = (state == FILL) && in_valid && !abort;
  assign last_lane = (lane_reg == LAST_LANE);
  assign last_row  = (row_reg == (rows_reg - AWIDTH'(1)));

  // Current row buffer with the incoming byte dropped into the active lane.
  for (genvar gi = 0; gi < DESIGN_SIZE; gi++) begin : g_lane
    assign row_merged[gi*DWIDTH +: DWIDTH] =
      (lane_reg == LW'(gi)) ? in_data : row_buf_reg[gi*DWIDTH +: DWIDTH];
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  // Next-state logic; abort overrides every transition out of FILL and WRITE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) state_next = (num_rows != '0) ? FILL : DONE;
      end
      FILL: begin
        if (abort)                  state_next = IDLE;
        else if (take && last_lane) state_next = WRITE;
      end
      WRITE: begin
        if (abort)         state_next = IDLE;
        else if (last_row) state_next = DONE;
        else               state_next = FILL;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode; the write strobe is suppressed by an abort in WRITE.
  always_comb begin
    in_ready = (state == FILL);
    busy     = (state != IDLE);
    done     = (state == DONE);
    we1      = ((state == WRITE) && !abort) ? '1 : '0;
  end

  // Load parameters, counters and row assembly. The RAM-facing address and
  // data are loaded together with the last byte of a row, so they are valid
  // throughout WRITE and simply hold afterwards.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      base_reg    <= '0;
      rows_reg    <= '0;
      row_reg     <= '0;
      lane_reg    <= '0;
      row_buf_reg <= '0;
      d1_reg      <= '0;
      addr1_reg   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && (num_rows != '0)) begin
            base_reg <= base_addr;
            rows_reg <= num_rows;
            row_reg  <= '0;
            lane_reg <= '0;
          end
        end
        FILL: begin
          if (take) begin
            row_buf_reg <= row_merged;
            lane_reg    <= last_lane ? '0 : lane_reg + LW'(1);
            if (last_lane) begin
              d1_reg    <= row_merged;
              addr1_reg <= base_reg + row_reg;
            end
          end
        end
        WRITE: begin
          if (!abort && !last_row) begin
            row_reg  <= row_reg + AWIDTH'(1);
            lane_reg <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign addr1 = addr1_reg;
  assign d1    = d1_reg;

endmodule

// File: tb/tb_ram_row_loader.sv
// tb_ram_row_loader: scoreboard bench for ram_row_loader. Expected RAM writes
// are queued as rows are prepared; a negedge monitor pops and compares them.
module tb_ram_row_loader;

  localparam int AW = 10;
  localparam int DS = 16;
  localparam int DW = 8;
  localparam int RW = DS * DW;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] num_rows = '0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic [AW-1:0] addr1;
  logic [RW-1:0] d1;
  logic [DS-1:0] we1;
  logic          busy;
  logic          done;

  ram_row_loader #(.AWIDTH(AW), .DESIGN_SIZE(DS), .DWIDTH(DW)) dut (
    .clk(clk), .resetn(resetn), .start(start), .abort(abort),
    .base_addr(base_addr), .num_rows(num_rows),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .addr1(addr1), .d1(d1), .we1(we1), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [RW-1:0] data;
  } wr_t;

  wr_t           exp_q[$];
  wr_t           mon_e;
  logic [RW-1:0] ram_model [0:(1<<AW)-1];
  logic [RW-1:0] sent_rows [0:15];
  logic [DW-1:0] stream_bytes [0:DS*16-1];
  int            checks = 0;
  int            failures = 0;
  int            write_count = 0;
  int            done_count = 0;

  // Write monitor: every RAM write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (resetn === 1'b1 && done === 1'b1) done_count++;
    if (resetn === 1'b1 && we1 !== '0) begin
      write_count++;
      ram_model[addr1] = d1;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write addr1=%0d we1=%h", addr1, we1);
      end else begin
        mon_e = exp_q.pop_front();
        if (we1 !== '1 || addr1 !== mon_e.addr || d1 !== mon_e.data) begin
          failures++;
          $display("FAIL row_write we1=%h addr1=%0d d1=%h required we1=%h addr1=%0d d1=%h",
                   we1, addr1, d1, {DS{1'b1}}, mon_e.addr, mon_e.data);
        end
      end
    end
  end

  // Build stream bytes for n rows and queue the writes they should produce.
  task automatic prepare_rows(input logic [AW-1:0] b, input int n, input bit rnd);
    logic [RW-1:0] row;
    logic [DW-1:0] by;
    for (int r = 0; r < n; r++) begin
      row = '0;
      for (int k = 0; k < DS; k++) begin
        by = rnd ? DW'($urandom_range(0, 255)) : DW'(r * DS + k);
        stream_bytes[r*DS + k] = by;
        row[k*DW +: DW] = by;
      end
      sent_rows[r] = row;
      exp_q.push_back({AW'(b + r), row});
    end
  endtask

  task automatic do_start(input logic [AW-1:0] b, input logic [AW-1:0] n);
    @(posedge clk); #1;
    base_addr = b;
    num_rows  = n;
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
  endtask

  // Feed n_bytes of stream_bytes, optionally with random stalls. Rows finished
  // inside the loop get a write-latency check; a row finished by the very last
  // byte is reported back to the caller through tail_pending.
  task automatic send_stream(input int n_bytes, input bit stall, output bit tail_pending);
    int idx = 0;
    int cyc = 0;
    bit pend = 1'b0;
    while (idx < n_bytes && cyc < 4000) begin
      in_valid = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_data  = stream_bytes[idx];
      @(negedge clk);
      if (pend) begin
        checks++;
        if (we1 !== '1) begin
          failures++;
          $display("FAIL write_latency we1=%h required=%h", we1, {DS{1'b1}});
        end
        pend = 1'b0;
      end
      if (in_valid && in_ready) begin
        idx++;
        if (idx % DS == 0) pend = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    if (idx < n_bytes) begin
      checks++;
      failures++;
      $display("FAIL stream_timeout accepted=%0d required=%0d", idx, n_bytes);
    end
    tail_pending = pend;
  endtask

  // Final row write, then the done pulse, then back to idle.
  task automatic check_tail();
    @(negedge clk);
    checks++;
    if (we1 !== '1) begin
      failures++;
      $display("FAIL last_write_latency we1=%h required=%h", we1, {DS{1'b1}});
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || we1 !== '0) begin
      failures++;
      $display("FAIL done_pulse done=%b we1=%h required done=1 we1=0", done, we1);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL done_end done=%b busy=%b required 0 0", done, busy);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_writes pending=%0d required=0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || we1 !== '0 ||
        addr1 !== '0 || d1 !== '0) begin
      failures++;
      $display("FAIL reset_state in_ready=%b busy=%b done=%b we1=%h addr1=%0d d1=%h required all 0",
               in_ready, busy, done, we1, addr1, d1);
    end
    @(posedge clk); #1;
    resetn = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_single_row(input logic [AW-1:0] b);
    bit tp;
    logic [RW-1:0] exp_row;
    prepare_rows(b, 1, 1'b0);
    exp_row = sent_rows[0];
    do_start(b, 1);
    send_stream(DS, 1'b0, tp);
    check_tail();
    checks++;
    if (d1 !== exp_row || addr1 !== b) begin
      failures++;
      $display("FAIL single_row_hold addr1=%0d d1=%h required addr1=%0d d1=%h", addr1, d1, b, exp_row);
    end
    $display("test_single_row base=%0d writes=%0d", b, write_count);
  endtask

  task automatic test_multi_row();
    bit tp;
    prepare_rows(0, 16, 1'b1);
    do_start(0, 16);
    send_stream(16 * DS, 1'b1, tp);
    check_tail();
    for (int r = 0; r < 16; r++) begin
      checks++;
      if (ram_model[r] !== sent_rows[r]) begin
        failures++;
        $display("FAIL readback row=%0d got=%h required=%h", r, ram_model[r], sent_rows[r]);
      end
    end
    $display("test_multi_row writes=%0d", write_count);
  endtask

  task automatic test_wrap();
    bit tp;
    logic [AW-1:0] a;
    prepare_rows(1022, 3, 1'b1);
    do_start(1022, 3);
    send_stream(3 * DS, 1'b1, tp);
    check_tail();
    for (int r = 0; r < 3; r++) begin
      a = AW'(1022 + r);
      checks++;
      if (ram_model[a] !== sent_rows[r]) begin
        failures++;
        $display("FAIL wrap_readback addr=%0d got=%h required=%h", a, ram_model[a], sent_rows[r]);
      end
    end
    $display("test_wrap writes=%0d", write_count);
  endtask

  task automatic test_zero_rows();
    int wc;
    wc = write_count;
    do_start(33, 0);
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || in_ready !== 1'b0 || we1 !== '0) begin
      failures++;
      $display("FAIL zero_rows_done done=%b in_ready=%b we1=%h required 1 0 0", done, in_ready, we1);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || write_count != wc) begin
      failures++;
      $display("FAIL zero_rows_end done=%b busy=%b in_ready=%b writes=%0d required 0 0 0 %0d",
               done, busy, in_ready, write_count, wc);
    end
    $display("test_zero_rows writes=%0d", write_count);
  endtask

  task automatic test_abort_fill();
    bit tp;
    int wc;
    int dc;
    wc = write_count;
    dc = done_count;
    prepare_rows(100, 3, 1'b1);
    void'(exp_q.pop_back());
    do_start(100, 3);
    send_stream(2 * DS + 7, 1'b1, tp);
    abort    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hA5;
    @(negedge clk);
    checks++;
    if (we1 !== '0) begin
      failures++;
      $display("FAIL abort_fill_we1 we1=%h required=0", we1);
    end
    @(posedge clk); #1;
    abort    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL abort_fill_idle busy=%b in_ready=%b required 0 0", busy, in_ready);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (write_count != wc + 2 || done_count != dc || exp_q.size() != 0) begin
      failures++;
      $display("FAIL abort_fill_effects writes=%0d dones=%0d pending=%0d required %0d %0d 0",
               write_count - wc, done_count - dc, exp_q.size(), 2, 0);
    end
    $display("test_abort_fill writes=%0d", write_count);
    test_single_row(9);
  endtask

  task automatic test_abort_write();
    bit tp;
    int wc;
    int dc;
    wc = write_count;
    dc = done_count;
    prepare_rows(7, 2, 1'b1);
    exp_q.delete();
    do_start(7, 2);
    send_stream(DS, 1'b0, tp);
    abort = 1'b1;
    @(negedge clk);
    checks++;
    if (we1 !== '0 || tp !== 1'b1) begin
      failures++;
      $display("FAIL abort_write_we1 we1=%h row_done=%b required we1=0 row_done=1", we1, tp);
    end
    @(posedge clk); #1;
    abort = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || write_count != wc || done_count != dc) begin
      failures++;
      $display("FAIL abort_write_effects busy=%b writes=%0d dones=%0d required 0 0 0",
               busy, write_count - wc, done_count - dc);
    end
    $display("test_abort_write writes=%0d", write_count);
  endtask

  task automatic test_reset_mid_fill();
    bit tp;
    int wc;
    int dc;
    wc = write_count;
    dc = done_count;
    prepare_rows(200, 2, 1'b1);
    exp_q.delete();
    do_start(200, 2);
    send_stream(5, 1'b0, tp);
    in_valid = 1'b1;
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || we1 !== '0 ||
        addr1 !== '0 || d1 !== '0) begin
      failures++;
      $display("FAIL async_reset in_ready=%b busy=%b done=%b we1=%h addr1=%0d d1=%h required all 0",
               in_ready, busy, done, we1, addr1, d1);
    end
    repeat (3) @(posedge clk);
    #1;
    start    = 1'b1;
    num_rows = '0;
    resetn   = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL start_after_reset done=%b required=1", done);
    end
    repeat (6) @(negedge clk);
    checks++;
    if (write_count != wc || done_count != dc + 1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_discard writes=%0d dones=%0d busy=%b required 0 1 0",
               write_count - wc, done_count - dc, busy);
    end
    in_valid = 1'b0;
    $display("test_reset_mid_fill writes=%0d", write_count);
  endtask

  initial begin
    test_reset();
    test_single_row(5);
    test_multi_row();
    test_wrap();
    test_zero_rows();
    test_abort_fill();
    test_abort_write();
    test_reset_mid_fill();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout time=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule
